nemesis_snd_cmd_tx: RTL and testbench
=====================================

NEMESIS_SND_CMD_TX -- requirements
Module: nemesis_snd_cmd_tx

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries, power of two, 2 to 16.
REQ-002 Parameter STROBE_W, default 8: low width, in i_clk cycles, of the /DATA and /SOUND_ON strobes; range 2 to 255.
REQ-003 Parameter ACK_TIMEOUT, default 65535: maximum ACK_WAIT length in cycles; 16-bit.
REQ-004 i_clk  in  1  48 MHz system clock; the only clock.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_cpu_db  in  8  main-CPU data byte, sampled when i_cmd_we=1.
REQ-007 i_cmd_we  in  1  one-cycle strobe from the main-CPU sound-latch write decode.
REQ-008 i_son_we  in  1  one-cycle strobe from the main-CPU sound-on write decode.
REQ-009 i_int_ack  in  1  sound Z80 interrupt acknowledge (IORQ-derived), active-high pulse.
REQ-010 o_main_db  out  8  byte presented to the sound-board data latch.
REQ-011 o_data_n  out  1  /DATA; the rising edge latches o_main_db.
REQ-012 o_sound_on_n  out  1  /SOUND_ON; interrupt request edge to the sound board.
REQ-013 o_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-014 o_full  out  1  FIFO count equals DEPTH.
REQ-015 o_overflow  out  1  sticky flag: at least one push was dropped.
REQ-016 o_timeout  out  1  one-cycle pulse when ACK_WAIT exits on timeout.

Function
REQ-017 Entry format: 9 bits {son, data}; i_cmd_we pushes {0, i_cpu_db}; i_son_we pushes {1, 8'h00}.
REQ-018 Full test uses the count at the start of the cycle; a push while full is dropped and sets o_overflow, even if a pop occurs in the same cycle.
REQ-019 i_cmd_we and i_son_we in the same cycle push two entries, cmd first; with exactly one free slot only cmd is stored, son is dropped and o_overflow is set.
REQ-020 FSM states: IDLE, D_SETUP, D_STB, D_HOLD, S_STB, ACK_WAIT.
REQ-021 IDLE with the FIFO non-empty: pop the head entry; son=0 goes to D_SETUP and son=1 goes to S_STB on the next cycle.
REQ-022 D_SETUP, 1 cycle: o_main_db <= entry data, o_data_n=1.
REQ-023 D_STB: o_data_n=0 for exactly STROBE_W cycles, o_main_db stable.
REQ-024 D_HOLD, 1 cycle: o_data_n=1, o_main_db stable; then IDLE.
REQ-025 o_main_db holds its last value in all other states.
REQ-026 S_STB: o_sound_on_n=0 for exactly STROBE_W cycles, then ACK_WAIT; o_main_db unchanged.
REQ-027 An i_int_ack seen during S_STB or ACK_WAIT sets the ack_seen flag; the flag clears on entry to S_STB.
REQ-028 ACK_WAIT exits to IDLE on the cycle after ack_seen=1, or after ACK_TIMEOUT cycles with o_timeout pulsed for 1 cycle.
REQ-029 i_int_ack outside S_STB and ACK_WAIT is ignored.
REQ-030 Latency from push into an empty FIFO in IDLE to o_data_n falling: 3 cycles (pop, D_SETUP, D_STB).
REQ-031 Latency from push to o_sound_on_n falling: 2 cycles.
REQ-032 Counters saturate and never wrap; FIFO pointers wrap modulo DEPTH.
REQ-033 o_data_n and o_sound_on_n are registered, glitch-free, and never low simultaneously.

Reset
REQ-034 While i_rst=1, asynchronously: o_main_db=8'h00, o_data_n=1, o_sound_on_n=1, o_overflow=0, o_timeout=0, FIFO emptied, state IDLE, ack_seen=0.
REQ-035 Reset asserted mid-strobe releases the strobe high immediately, and no entry survives.

Structure
REQ-036 Package nemesis_snd_pkg holds the FSM state enum, the 9-bit entry typedef, and the STROBE_W and ACK_TIMEOUT defaults.
REQ-037 One sub-module, nemesis_snd_fifo (synchronous, parameterised width and depth, registered count), holds the entries.
REQ-038 The FSM, strobe counter and timeout counter live in the top module.

Verification
REQ-039 Push cmd 8'hA5 -> o_data_n low 3 cycles later for 8 cycles; o_main_db=8'hA5 from 1 cycle before the fall until at least 1 cycle after the rise.
REQ-040 Same-cycle cmd 8'h3C + son; i_int_ack 20 cycles after the /SOUND_ON fall -> /DATA pulse, then /SOUND_ON pulse, then IDLE; o_busy falls after ack.
REQ-041 Son with no ack, ACK_TIMEOUT=100 -> o_timeout pulses exactly 100 cycles after ACK_WAIT entry; the next entry then starts.
REQ-042 With the FSM stalled in ACK_WAIT, 5 cmd pushes at DEPTH=4 -> o_full=1, the 5th is dropped, o_overflow=1 and stays set; the 4 bytes go out in order.
REQ-043 i_rst asserted mid-D_STB with 2 entries queued -> o_data_n=1 within the same cycle, o_main_db=8'h00, o_busy=0, and no strobe after release.

Source files
------------

// File: rtl/nemesis_snd_pkg.sv
// Shared types and defaults for the sound-board command transmitter.
package nemesis_snd_pkg;

  localparam int STROBE_W_DEF    = 8;
  localparam int ACK_TIMEOUT_DEF = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_SETUP,
    ST_D_STB,
    ST_D_HOLD,
    ST_S_STB,
    ST_ACK_WAIT
  } state_t;

  typedef struct packed {
    logic       son;
    logic [7:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/nemesis_snd_fifo.sv
// Command FIFO with two write ports per cycle (port 0 lands ahead of port 1).
// The caller guarantees writes never exceed free space and pops never hit empty.
module nemesis_snd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push0,
  input  logic [WIDTH-1:0]       i_din0,
  input  logic                   i_push1,
  input  logic [WIDTH-1:0]       i_din1,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, wptr1;
  logic [CW-1:0]    cnt_q;

  assign wptr1 = wptr_q + AW'(i_push0);

  always_ff @(posedge i_clk) begin
    if (i_push0) mem_q[wptr_q] <= i_din0;
    if (i_push1) mem_q[wptr1]  <= i_din1;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(i_push0) + AW'(i_push1);
      rptr_q <= rptr_q + AW'(i_pop);
      cnt_q  <= cnt_q + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  assign o_head  = mem_q[rptr_q];
  assign o_count = cnt_q;
  assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/nemesis_snd_cmd_tx.sv
// Queues main-CPU sound commands and plays them out to the sound board as
// /DATA byte strobes or /SOUND_ON interrupt strobes with an ack handshake.
module nemesis_snd_cmd_tx
  import nemesis_snd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int STROBE_W    = STROBE_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_cpu_db,
  input  logic       i_cmd_we,
  input  logic       i_son_we,
  input  logic       i_int_ack,
  output logic [7:0] o_main_db,
  output logic       o_data_n,
  output logic       o_sound_on_n,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state_q;
  logic [7:0]    main_db_q;
  logic          data_n_q, son_n_q, ovf_q, tmo_q, ack_q;
  logic [7:0]    stb_cnt_q;
  logic [15:0]   to_cnt_q;

  logic [CW-1:0] cnt;
  logic          empty, cmd_ok, son_ok, pop;
  entry_t        head, cmd_ent, son_ent;

  // Space is judged on the count at the start of the cycle; a same-cycle pop
  // does not make room.
  assign cmd_ok  = i_cmd_we && (cnt < CW'(DEPTH));
  assign son_ok  = i_son_we && ((cnt + CW'(cmd_ok)) < CW'(DEPTH));
  assign pop     = (state_q == ST_IDLE) && !empty;
  assign cmd_ent = '{son: 1'b0, data: i_cpu_db};
  assign son_ent = '{son: 1'b1, data: 8'h00};

  nemesis_snd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push0 (cmd_ok),
    .i_din0  (cmd_ent),
    .i_push1 (son_ok),
    .i_din1  (son_ent),
    .i_pop   (pop),
    .o_head  (head),
    .o_count (cnt),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      main_db_q <= 8'h00;
      data_n_q  <= 1'b1;
      son_n_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      ack_q     <= 1'b0;
      stb_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      tmo_q <= 1'b0;
      if ((i_cmd_we && !cmd_ok) || (i_son_we && !son_ok)) ovf_q <= 1'b1;
      if ((state_q == ST_S_STB || state_q == ST_ACK_WAIT) && i_int_ack) ack_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            stb_cnt_q <= '0;
            if (head.son) begin
              state_q <= ST_S_STB;
              son_n_q <= 1'b0;
              ack_q   <= 1'b0;
            end else begin
              state_q   <= ST_D_SETUP;
              main_db_q <= head.data;
            end
          end
        end
        ST_D_SETUP: begin
          state_q  <= ST_D_STB;
          data_n_q <= 1'b0;
        end
        ST_D_STB: begin
          if (stb_cnt_q == 8'(STROBE_W - 1)) begin
            state_q  <= ST_D_HOLD;
            data_n_q <= 1'b1;
          end else if (stb_cnt_q != 8'hFF) begin
            stb_cnt_q <= stb_cnt_q + 8'd1;
          end
        end
        ST_D_HOLD: state_q <= ST_IDLE;
        ST_S_STB: begin
          if (stb_cnt_q == 8'(STROBE_W - 1)) begin
            state_q  <= ST_ACK_WAIT;
            son_n_q  <= 1'b1;
            to_cnt_q <= '0;
          end else if (stb_cnt_q != 8'hFF) begin
            stb_cnt_q <= stb_cnt_q + 8'd1;
          end
        end
        ST_ACK_WAIT: begin
          // An ack seen earlier wins over a timeout landing on the same cycle.
          if (ack_q) begin
            state_q <= ST_IDLE;
          end else if (to_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
            tmo_q   <= 1'b1;
          end else if (to_cnt_q != 16'hFFFF) begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_main_db    = main_db_q;
  assign o_data_n     = data_n_q;
  assign o_sound_on_n = son_n_q;
  assign o_overflow   = ovf_q;
  assign o_timeout    = tmo_q;
  assign o_full       = (cnt == CW'(DEPTH));
  assign o_busy       = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_nemesis_snd_cmd_tx.sv
// Scoreboard bench: a timing model predicts each strobe, timeout and status
// per edge; a monitor process compares the DUT against those predictions.
module tb_nemesis_snd_cmd_tx;
  localparam int DEPTH = 4;
  localparam int SW    = 8;
  localparam int TO    = 100;

  logic       i_clk = 1'b0, i_rst = 1'b1;
  logic [7:0] i_cpu_db = 8'h00;
  logic       i_cmd_we = 1'b0, i_son_we = 1'b0, i_int_ack = 1'b0;
  logic [7:0] o_main_db;
  logic       o_data_n, o_sound_on_n, o_busy, o_full, o_overflow, o_timeout;

  nemesis_snd_cmd_tx #(.DEPTH(DEPTH), .STROBE_W(SW), .ACK_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpu_db(i_cpu_db), .i_cmd_we(i_cmd_we),
    .i_son_we(i_son_we), .i_int_ack(i_int_ack), .o_main_db(o_main_db),
    .o_data_n(o_data_n), .o_sound_on_n(o_sound_on_n), .o_busy(o_busy),
    .o_full(o_full), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  always #10 i_clk = ~i_clk;

  typedef struct { bit son; logic [7:0] val; int fall; } ev_t;
  typedef struct { int k; bit busy; bit full; bit ovf; } st_t;

  ev_t         evq[$];
  int          tmoq[$];
  st_t         stq[$];
  logic [8:0]  mq[$];
  int          ecnt = 0;
  int          idle_from = 0, son_pop = -1, son_e = -1, ack_at = -1;
  int          ack_mode = 0;
  bit          m_ovf = 0, spur_en = 0, mon_en = 0;
  logic [7:0]  last_db = 8'h00;
  int          checks = 0, passes = 0;

  always @(posedge i_clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // One cycle of stimulus; the model advances to the state after edge k.
  task automatic step(input bit cw, input bit sw, input logic [7:0] db);
    int k, cnt0, ex;
    bit cok, sok, spur;
    logic [8:0] e;
    ev_t ev;
    st_t st;
    @(negedge i_clk);
    k    = ecnt;
    cnt0 = mq.size();
    if (k >= idle_from && mq.size() > 0) begin
      e = mq.pop_front();
      if (!e[8]) begin
        last_db = e[7:0];
        ev.son = 1'b0; ev.val = e[7:0]; ev.fall = k + 1;
        idle_from = k + SW + 3;
      end else begin
        son_pop = k;
        if (ack_mode == 0)      ack_at = k + 1 + int'($urandom_range(0, SW + 120));
        else if (ack_mode == 1) ack_at = k + 20;
        else                    ack_at = -1;
        ex = (ack_at + 1 > k + SW + 1) ? ack_at + 1 : k + SW + 1;
        if (ack_at < 0 || ex > k + SW + TO) begin
          ex = k + SW + TO;
          tmoq.push_back(ex);
        end
        son_e = ex;
        idle_from = ex + 1;
        ev.son = 1'b1; ev.val = last_db; ev.fall = k;
      end
      evq.push_back(ev);
    end
    cok = cw && (cnt0 < DEPTH);
    sok = sw && ((cnt0 + int'(cok)) < DEPTH);
    if ((cw && !cok) || (sw && !sok)) m_ovf = 1'b1;
    if (cok) mq.push_back({1'b0, db});
    if (sok) mq.push_back(9'h100);
    st.k = k; st.busy = (mq.size() > 0) || (k < idle_from - 1);
    st.full = (mq.size() == DEPTH); st.ovf = m_ovf;
    stq.push_back(st);
    spur = spur_en && ($urandom_range(0, 7) == 0) && !(son_pop >= 0 && k > son_pop && k <= son_e);
    i_int_ack = (ack_at >= 0 && k == ack_at) || spur;
    i_cmd_we  = cw;
    i_son_we  = sw;
    i_cpu_db  = db;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'($urandom));
  endtask

  // Monitor: compares every completed strobe, timeout pulse and per-edge status.
  initial begin
    bit pdn = 1'b1, psn = 1'b1;
    int fall_d = 0, fall_s = 0, L;
    logic [7:0] pdb = 8'h00;
    ev_t ev;
    st_t st;
    forever begin
      @(negedge i_clk);
      if (i_rst || !mon_en) begin
        pdn = 1'b1; psn = 1'b1; pdb = o_main_db;
        continue;
      end
      L = ecnt - 1;
      if (stq.size() > 0 && stq[0].k == L) begin
        st = stq.pop_front();
        chk("busy", o_busy, st.busy);
        chk("full", o_full, st.full);
        chk("overflow", o_overflow, st.ovf);
      end
      chk("strobes_exclusive", o_data_n | o_sound_on_n, 1);
      if (pdn && !o_data_n) begin
        fall_d = L;
        if (evq.size() > 0) chk("db_setup", pdb, evq[0].val);
      end
      if (!pdn && o_data_n) begin
        chk("data_event_pending", evq.size() > 0, 1);
        if (evq.size() > 0) begin
          ev = evq.pop_front();
          chk("data_kind", ev.son, 0);
          chk("data_hold_byte", o_main_db, ev.val);
          chk("data_fall_edge", fall_d, ev.fall);
          chk("data_width", L - fall_d, SW);
        end
      end
      if (psn && !o_sound_on_n) begin
        fall_s = L;
        if (evq.size() > 0) chk("son_db_unchanged", o_main_db, evq[0].val);
      end
      if (!psn && o_sound_on_n) begin
        chk("son_event_pending", evq.size() > 0, 1);
        if (evq.size() > 0) begin
          ev = evq.pop_front();
          chk("son_kind", ev.son, 1);
          chk("son_fall_edge", fall_s, ev.fall);
          chk("son_width", L - fall_s, SW);
        end
      end
      if (o_timeout) begin
        chk("timeout_pending", tmoq.size() > 0, 1);
        if (tmoq.size() > 0) chk("timeout_edge", L, tmoq.pop_front());
      end
      pdn = o_data_n; psn = o_sound_on_n; pdb = o_main_db;
    end
  end

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_data_n", o_data_n, 1);
    chk("rst_sound_on_n", o_sound_on_n, 1);
    chk("rst_main_db", o_main_db, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_full", o_full, 0);
    i_rst = 1'b0; mon_en = 1'b1;

    // Single command byte.
    step(1'b1, 1'b0, 8'hA5); idle(20);
    // Command and sound-on in the same cycle, acked 20 cycles after the fall.
    ack_mode = 1; step(1'b1, 1'b1, 8'h3C); idle(60);
    // Unacked sound-on times out; the queued byte follows.
    ack_mode = 2; step(1'b0, 1'b1, 8'h00); step(1'b1, 1'b0, 8'h5A); idle(SW + TO + 40);
    // Stall in ACK_WAIT and overfill the FIFO.
    step(1'b0, 1'b1, 8'h00); idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    idle(SW + TO + 80);
    // One free slot with cmd+son together.
    step(1'b0, 1'b1, 8'h00); idle(4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'h77);
    idle(SW + TO + 80);

    // Randomised traffic with random ack delays and stray acks.
    ack_mode = 0; spur_en = 1'b1;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    spur_en = 1'b0;
    idle(300);

    // Reset in the middle of a /DATA strobe with two entries still queued.
    ack_mode = 1;
    step(1'b1, 1'b0, 8'hC1); step(1'b1, 1'b0, 8'hC2); step(1'b1, 1'b0, 8'hC3);
    idle(4);
    @(posedge i_clk); #2;
    chk("pre_rst_in_dstb", o_data_n, 0);
    i_rst = 1'b1; #1;
    chk("midrst_data_n", o_data_n, 1);
    chk("midrst_main_db", o_main_db, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_overflow", o_overflow, 0);
    mq.delete(); evq.delete(); tmoq.delete(); stq.delete();
    idle_from = 0; son_pop = -1; son_e = -1; ack_at = -1; m_ovf = 1'b0; last_db = 8'h00;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    idle(40);

    chk("events_drained", evq.size(), 0);
    chk("timeouts_drained", tmoq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
